// File: rtl/imem_prefetch.sv
// Sequential instruction prefetcher: issues credit-limited reads to a fixed-latency RAM and
// queues returned words in program order, with redirect/kill and halt/drain support.
module imem_prefetch #(
    parameter int ADDR_W      = 64,
    parameter int DATA_W      = 64,
    parameter int INSN_BYTES  = 8,
    parameter int MEM_LATENCY = 1,
    parameter int DEPTH       = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_redirect,
    input  logic [ADDR_W-1:0] i_redirect_pc,
    input  logic              i_halt,
    output logic              o_halted,
    output logic              o_fetch_valid,
    input  logic              i_fetch_ready,
    output logic [DATA_W-1:0] o_fetch_data,
    output logic [ADDR_W-1:0] o_fetch_pc,
    output logic              o_mem_cs,
    output logic [ADDR_W-1:0] o_mem_addr,
    input  logic [DATA_W-1:0] i_mem_rdata
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int SW    = $clog2(DEPTH + MEM_LATENCY + 1);
    localparam logic [ADDR_W-1:0] PC_MASK = ~ADDR_W'(INSN_BYTES - 1);

    localparam logic [1:0] S_RUN    = 2'd0;
    localparam logic [1:0] S_DRAIN  = 2'd1;
    localparam logic [1:0] S_HALTED = 2'd2;

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_nextPc;
    logic [MEM_LATENCY-1:0] r_ifValid;
    logic [ADDR_W-1:0] r_ifPc [MEM_LATENCY];
    logic [DATA_W-1:0] r_fifoData [DEPTH];
    logic [ADDR_W-1:0] r_fifoPc [DEPTH];
    logic [PTR_W-1:0]  r_wrPtr;
    logic [PTR_W-1:0]  r_rdPtr;
    logic [SW-1:0]     r_count;

    logic [SW-1:0] w_inflight;
    logic          w_issue;
    logic          w_push;
    logic          w_pop;

    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < MEM_LATENCY; i++) begin
            w_inflight = w_inflight + SW'(r_ifValid[i]);
        end
    end

    // Credit counts buffered words plus reads in flight; a same-cycle pop earns no credit.
    assign w_issue = !i_rst && (r_state == S_RUN) && !i_halt && !i_redirect &&
                     ((r_count + w_inflight) < SW'(DEPTH));
    assign w_push  = r_ifValid[MEM_LATENCY-1] && !i_redirect;
    assign w_pop   = o_fetch_valid && i_fetch_ready;

    assign o_mem_cs      = w_issue;
    assign o_mem_addr    = r_nextPc;
    assign o_halted      = (r_state == S_HALTED);
    assign o_fetch_valid = (r_count != '0);
    assign o_fetch_data  = o_fetch_valid ? r_fifoData[r_rdPtr] : '0;
    assign o_fetch_pc    = o_fetch_valid ? r_fifoPc[r_rdPtr] : '0;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_RUN;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (i_halt) begin
                        r_state <= (w_inflight == '0) ? S_HALTED : S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (!i_halt) begin
                        r_state <= S_RUN;
                    end else if (w_inflight == '0) begin
                        r_state <= S_HALTED;
                    end
                end
                S_HALTED: begin
                    if (!i_halt) begin
                        r_state <= S_RUN;
                    end
                end
                default: r_state <= S_RUN;
            endcase
        end
    end

    // Redirect kills every outstanding read so its returning data never reaches the FIFO.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ifValid <= '0;
            for (int i = 0; i < MEM_LATENCY; i++) begin
                r_ifPc[i] <= '0;
            end
        end else if (i_redirect) begin
            r_ifValid <= '0;
        end else begin
            r_ifValid[0] <= w_issue;
            r_ifPc[0]    <= r_nextPc;
            for (int i = 1; i < MEM_LATENCY; i++) begin
                r_ifValid[i] <= r_ifValid[i-1];
                r_ifPc[i]    <= r_ifPc[i-1];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_nextPc <= RESET_PC;
        end else if (i_redirect) begin
            r_nextPc <= i_redirect_pc & PC_MASK;
        end else if (w_issue) begin
            r_nextPc <= r_nextPc + ADDR_W'(INSN_BYTES);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || i_redirect) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + SW'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - SW'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst && w_push) begin
            r_fifoData[r_wrPtr] <= i_mem_rdata;
            r_fifoPc[r_wrPtr]   <= r_ifPc[MEM_LATENCY-1];
        end
    end

endmodule
